rc4_sbox_mem: RTL and testbench
===============================

// Module: rc4_sbox_mem
// PURPOSE
//  Parametrised RC4 state (S-box) memory. Next generation of the 16x4 key-state store.
//  Adds configurable width/depth, async reset of control, a hardware identity-fill
//  sequence (S[k]=k) and an atomic two-cycle swap S[a]<->S[b], as required by RC4 KSA/PRGA.
//  Sits between the RC4 key-schedule/keystream controller and the cipher datapath.
// PARAMETERS
//  ADDR_W  8  address width; DEPTH = 2**ADDR_W entries
//  DATA_W  8  entry width; must be >= ADDR_W (identity fill needs it)
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  init_start  in   1       start identity fill (sampled only when !busy)
//  swap_start  in   1       start swap of swap_a/swap_b (sampled only when !busy)
//  swap_a      in   ADDR_W  swap index A, latched at accept
//  swap_b      in   ADDR_W  swap index B, latched at accept
//  wr_en       in   1       single write strobe
//  wr_addr     in   ADDR_W  write address
//  wr_data     in   DATA_W  write data
//  rd_en       in   1       single read strobe
//  rd_addr     in   ADDR_W  read address
//  rd_data     out  DATA_W  registered read data, held until next read
//  rd_valid    out  1       1-cycle pulse, rd_data updated this cycle
//  busy        out  1       1 while INIT or SWAP in progress
//  done        out  1       1-cycle pulse at end of init or swap
// BEHAVIOUR
//  - Reset (rst_n=0): FSM=IDLE, rd_data=0, rd_valid=0, busy=0, done=0, index ctr=0,
//    swap latches=0. Memory array NOT reset; contents undefined until init completes.
//  - FSM states: IDLE, INIT, SWAP_RD, SWAP_WR.
//  - IDLE command priority, one per cycle: init_start > swap_start > wr/rd.
//  - Any start accepted: busy=1 from next cycle. While busy, all of init_start,
//    swap_start, wr_en, rd_en are dropped (no effect, no rd_valid).
//  - wr_en only: mem[wr_addr]<=wr_data. rd_en only: rd_data<=mem[rd_addr], rd_valid=1
//    next cycle (latency 1). wr_en&&rd_en same cycle: both dropped (legacy rule).
//  - INIT: DEPTH cycles, cycle k writes mem[k]<=k zero-extended to DATA_W; ctr wraps
//    DEPTH-1->0; after last write -> IDLE, done=1 for 1 cycle, busy=0 same cycle.
//  - SWAP_RD: ta<=mem[a], tb<=mem[b]. SWAP_WR: mem[a]<=tb, mem[b]<=ta -> IDLE, done=1.
//    Accept->done = 2 cycles after accept edge. a==b: contents unchanged, timing same.
//  - rd_data after swap/init unchanged (only rd_en updates it).
//  - rst_n asserted mid-INIT/SWAP: abort immediately to IDLE, no done; entries already
//    written stay written, in-flight swap may leave one or zero entries updated - caller
//    must re-init.
// CONFIGURATION
//  RC4_SBOX_ERR_EN defined: adds output port err (1 bit), sticky, reset 0; set on any
//    dropped command (strobe while busy, or wr_en&&rd_en together); cleared on init accept.
//  Not defined: no err port; drops are silent; all other behaviour identical.
// TESTING
//  1 rst_n low mid-stream -> rd_data=0, busy=0, done=0, rd_valid=0 immediately (async).
//  2 init_start 1 cyc (ADDR_W=8) -> busy 256 cyc, done pulse; rd_en addr 0x37 -> 0x37.
//  3 after init, swap a=0x05 b=0xA0 -> done 2 cyc after accept; rd 0x05=0xA0, 0xA0=0x05.
//  4 swap a=b=0x10 -> done after 2 cyc, rd 0x10=0x10; wr 0x10<=0x5A then rd -> 0x5A next cyc.
//  5 wr_en&&rd_en same cycle, and wr_en during busy -> mem unchanged, no rd_valid;
//    with RC4_SBOX_ERR_EN err=1 until next init_start accept.
//  6 init_start and swap_start same IDLE cycle -> INIT runs, swap dropped; rst_n low at
//    init cycle 100 -> IDLE, no done, entries 0..99 hold identity.

Source files
------------

// File: rtl/rc4_sbox_mem.sv
// RC4 S-box state memory: DEPTH = 2**ADDR_W entries of DATA_W bits.
// Provides single-port style read/write access, a hardware identity fill
// (S[k] = k) and an atomic two-cycle swap S[a] <-> S[b].
// Optional build macro RC4_SBOX_ERR_EN adds a sticky 'err' output that flags
// dropped commands; it is cleared when an init is accepted.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepts one command per cycle: init > swap > write/read
// INIT    | writes mem[ctr] <= ctr, one entry per cycle, DEPTH cycles
// SWAP_RD | captures mem[a] and mem[b] into the temporaries
// SWAP_WR | writes the temporaries back crossed over, then done

module rc4_sbox_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    input  logic              swap_start,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
`ifdef RC4_SBOX_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INIT    = 2'd1,
        S_SWAP_RD = 2'd2,
        S_SWAP_WR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ctr;
    logic [ADDR_W-1:0] lat_a;
    logic [ADDR_W-1:0] lat_b;
    logic [DATA_W-1:0] tmp_a;
    logic [DATA_W-1:0] tmp_b;
    logic [DATA_W-1:0] mem [DEPTH];

    logic idle;
    logic accept_init;
    logic accept_swap;
    logic cmd_free;
    logic do_wr;
    logic do_rd;
    logic init_last;
    logic finish;

    // Command decode: only IDLE accepts anything, and only one command per cycle.
    always_comb begin
        idle        = (state == S_IDLE);
        accept_init = idle && init_start;
        accept_swap = idle && !init_start && swap_start;
        cmd_free    = idle && !init_start && !swap_start;
        // A write and read in the same cycle cancel each other out.
        do_wr       = cmd_free && wr_en && !rd_en;
        do_rd       = cmd_free && rd_en && !wr_en;
        init_last   = (state == S_INIT) && (ctr == {ADDR_W{1'b1}});
    end

    // State register; reset aborts any fill or swap in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_init) begin
                    state_nxt = S_INIT;
                end else if (accept_swap) begin
                    state_nxt = S_SWAP_RD;
                end
            end
            S_INIT: begin
                if (init_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SWAP_RD: state_nxt = S_SWAP_WR;
            S_SWAP_WR: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy follows the state register, finish marks the last busy cycle.
    always_comb begin
        busy   = (state != S_IDLE);
        finish = init_last || (state == S_SWAP_WR);
    end

    // Control and datapath registers that must come out of reset in a known state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr      <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            done     <= finish;
            if (do_rd) begin
                rd_data <= mem[rd_addr];
            end
            if (accept_init) begin
                ctr <= '0;
            end else if (state == S_INIT) begin
                ctr <= ctr + 1'b1;  // wraps to 0 after the last entry
            end
            if (accept_swap) begin
                lat_a <= swap_a;
                lat_b <= swap_b;
            end
            if (state == S_SWAP_RD) begin
                tmp_a <= mem[lat_a];
                tmp_b <= mem[lat_b];
            end
        end
    end

    // Storage array; deliberately not reset, contents are defined by an init.
    // With a == b both swap writes carry the same value, so the entry is unchanged.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_addr] <= wr_data;
        end
        if (state == S_INIT) begin
            mem[ctr] <= DATA_W'(ctr);
        end
        if (state == S_SWAP_WR) begin
            mem[lat_a] <= tmp_b;
            mem[lat_b] <= tmp_a;
        end
    end

`ifdef RC4_SBOX_ERR_EN
    logic drop;

    // A command is dropped if it arrives while busy or as a write/read collision.
    always_comb begin
        drop = (!idle && (init_start || swap_start || wr_en || rd_en)) ||
               (cmd_free && wr_en && rd_en);
    end

    // Sticky error flag, cleared by the next accepted init.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept_init) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rc4_sbox_mem.sv
// Self-checking bench for rc4_sbox_mem (ADDR_W = DATA_W = 8).
// Reads push their expected value from a local memory model into a queue;
// a monitor pops and compares whenever rd_valid is seen.

module tb_rc4_sbox_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_start;
    logic       swap_start;
    logic [7:0] swap_a;
    logic [7:0] swap_b;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
`ifdef RC4_SBOX_ERR_EN
    logic       err;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model [256];
    logic [7:0] sb [$];
    logic [7:0] last_rd;
    logic [7:0] mon_exp;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    op_t ops [10];

    always #5 clk = ~clk;

    rc4_sbox_mem #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .swap_start (swap_start),
        .swap_a     (swap_a),
        .swap_b     (swap_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done)
`ifdef RC4_SBOX_ERR_EN
        ,
        .err        (err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read-data scoreboard: every rd_valid must match the oldest queued read.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 (rd_data %0h), expected no read", rd_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rd_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL rd_data: got %0h, expected %0h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        init_start = 1'b0;
        swap_start = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr);
        sb.push_back(model[addr]);
        last_rd = model[addr];
        rd_en   = 1'b1;
        rd_addr = addr;
        step();
        rd_en   = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
        model[addr] = data;
    endtask

    task automatic run_init();
        int cnt;
        init_start = 1'b1;
        step();
        clr_in();
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            step();
        end
        chk("init_busy_cycles", cnt, 256);
        chk("init_done_pulse", done, 1);
        chk("init_busy_low_at_done", busy, 0);
`ifdef RC4_SBOX_ERR_EN
        chk("init_clears_err", err, 0);
`endif
        step();
        chk("init_done_one_cycle", done, 0);
        for (int k = 0; k < 256; k++) model[k] = 8'(k);
    endtask

    task automatic run_swap(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        swap_start = 1'b1;
        swap_a     = a;
        swap_b     = b;
        step();
        swap_start = 1'b0;
        chk("swap_busy_c1", busy, 1);
        chk("swap_no_done_c1", done, 0);
        step();
        chk("swap_busy_c2", busy, 1);
        step();
        chk("swap_done", done, 1);
        chk("swap_busy_low", busy, 0);
        step();
        chk("swap_done_one_cycle", done, 0);
        chk("swap_rd_data_held", rd_data, last_rd);
        t = model[a];
        model[a] = model[b];
        model[b] = t;
    endtask

    initial begin
        ops[0] = '{1'b1, 8'h00, 8'hFF};
        ops[1] = '{1'b1, 8'hFF, 8'h00};
        ops[2] = '{1'b0, 8'h00, 8'h00};
        ops[3] = '{1'b0, 8'hFF, 8'h00};
        ops[4] = '{1'b1, 8'h80, 8'h3C};
        ops[5] = '{1'b0, 8'h80, 8'h00};
        ops[6] = '{1'b0, 8'h7F, 8'h00};
        ops[7] = '{1'b1, 8'h64, 8'hAA};
        ops[8] = '{1'b0, 8'h64, 8'h00};
        ops[9] = '{1'b0, 8'h37, 8'h00};

        rst_n   = 1'b0;
        clr_in();
        swap_a  = '0;
        swap_b  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        last_rd = '0;
        #12;
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
`ifdef RC4_SBOX_ERR_EN
        chk("reset_err", err, 0);
`endif
        #5 rst_n = 1'b1;
        step();

        // Identity fill then a read of 0x37.
        run_init();
        do_read(8'h37);

        // Swap of distinct indices.
        run_swap(8'h05, 8'hA0);
        do_read(8'h05);
        do_read(8'hA0);

        // Self-swap, then a write/read of the same entry.
        run_swap(8'h10, 8'h10);
        do_read(8'h10);
        do_write(8'h10, 8'h5A);
        do_read(8'h10);

        // Table-driven writes and reads, including address extremes.
        for (int i = 0; i < 10; i++) begin
            if (ops[i].is_wr) do_write(ops[i].addr, ops[i].data);
            else              do_read(ops[i].addr);
        end

        // Write and read together: both dropped.
        wr_en   = 1'b1;
        wr_addr = 8'h20;
        wr_data = 8'hEE;
        rd_en   = 1'b1;
        rd_addr = 8'h20;
        step();
        clr_in();
        chk("collision_no_rd_valid", rd_valid, 0);
`ifdef RC4_SBOX_ERR_EN
        chk("collision_sets_err", err, 1);
`endif
        do_read(8'h20);

        // Strobes while busy with a swap are all dropped.
        swap_start = 1'b1;
        swap_a     = 8'h01;
        swap_b     = 8'h02;
        step();
        swap_start = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 8'h30;
        wr_data    = 8'h99;
        rd_en      = 1'b1;
        rd_addr    = 8'h30;
        init_start = 1'b1;
        step();
        clr_in();
        chk("busy_drop_no_rd_valid", rd_valid, 0);
        chk("busy_drop_still_busy", busy, 1);
        step();
        chk("busy_drop_swap_done", done, 1);
        step();
        chk("busy_drop_no_init", busy, 0);
`ifdef RC4_SBOX_ERR_EN
        chk("busy_drop_err", err, 1);
`endif
        model[8'h01] = 8'h02;
        model[8'h02] = 8'h01;
        do_read(8'h30);
        do_read(8'h01);
        do_read(8'h02);

        // Asynchronous reset while rd_valid is high.
        do_read(8'h80);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_data", rd_data, 0);
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_busy", busy, 0);
        sb.delete();
        #5 rst_n = 1'b1;
        step();

        // Init and swap together: init wins; reset after 100 entries are written.
        init_start = 1'b1;
        swap_start = 1'b1;
        swap_a     = 8'hA0;
        swap_b     = 8'hC8;
        step();
        clr_in();
        chk("prio_init_busy", busy, 1);
`ifdef RC4_SBOX_ERR_EN
        chk("prio_init_clears_err", err, 0);
`endif
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) chk("partial_init_no_done", done, 0);
        end
        chk("partial_init_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        #5 rst_n = 1'b1;
        step();
        for (int k = 0; k < 100; k++) model[k] = 8'(k);
        do_read(8'h01);
        do_read(8'h05);
        do_read(8'h10);
        do_read(8'h63);
        do_read(8'h64);
        do_read(8'hA0);
        do_read(8'hC8);

        // A full init after the abort starts again from entry 0.
        run_init();
        do_read(8'hFF);
        do_read(8'h64);
        do_read(8'h00);
        step();
        step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
